// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared score width constants and reader state encoding
package score_pkg;

    localparam int SCORE_ADDR_WIDTH = 8;
    localparam int SCORE_DATA_WIDTH = 32;
    localparam int SCORE_NUM_DIGITS = 10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_CONVERT = 3'd3,
        S_PRESENT = 3'd4,
        S_FINISH  = 3'd5
    } reader_state_e;

endpackage

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble converter with leading-zero blank mask
module bin_to_bcd
    import score_pkg::*;
#(
    parameter int DATA_WIDTH = SCORE_DATA_WIDTH,
    parameter int NUM_DIGITS = SCORE_NUM_DIGITS
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   blank_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int BW = 4 * NUM_DIGITS;

    logic [DATA_WIDTH-1:0] bin_q;
    logic [BW-1:0]         bcd_q;
    logic [CW-1:0]         cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic [NUM_DIGITS-1:0] blank_q;

    logic [DATA_WIDTH-1:0]    src_bin;
    logic [BW-1:0]            adj;
    logic [BW+DATA_WIDTH-1:0] shifted;
    logic [BW-1:0]            next_bcd;
    logic [DATA_WIDTH-1:0]    next_bin;
    logic [NUM_DIGITS-1:0]    next_blank;
    logic [CW-1:0]            next_cnt;
    logic                     all_zero;
    logic                     last;

    // One double-dabble step; a load performs the first step on the fresh word directly
    always_comb begin
        src_bin = load_i ? data_i : bin_q;
        adj     = load_i ? '0 : bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        shifted  = {adj, src_bin} << 1;
        next_bcd = shifted[BW+DATA_WIDTH-1 -: BW];
        next_bin = shifted[DATA_WIDTH-1:0];
        all_zero = 1'b1;
        next_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero      = all_zero & (next_bcd[4*k +: 4] == 4'd0);
            next_blank[k] = all_zero;
        end
        next_blank[0] = 1'b0;
        next_cnt = load_i ? CW'(1) : cnt_q + CW'(1);
        last     = (next_cnt == CW'(DATA_WIDTH));
    end

    // Iterate once per cycle while busy; latch the blank mask with the final step
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            blank_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (load_i || busy_q) begin
                bin_q  <= next_bin;
                bcd_q  <= next_bcd;
                cnt_q  <= next_cnt;
                busy_q <= !last;
                if (last) begin
                    done_q  <= 1'b1;
                    blank_q <= next_blank;
                end
            end
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign digits_o = bcd_q;
    assign blank_o  = blank_q;

endmodule

// File: rtl/score_history_reader.sv
// rtl/score_history_reader.sv - newest-first score memory reader feeding BCD entries to the renderer
module score_history_reader
    import score_pkg::*;
#(
    parameter int ADDR_WIDTH = SCORE_ADDR_WIDTH,
    parameter int DATA_WIDTH = SCORE_DATA_WIDTH,
    parameter int NUM_DIGITS = SCORE_NUM_DIGITS,
    parameter int ENTRIES    = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                         Clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [ADDR_WIDTH-1:0]        latestAddress,
    output logic [ADDR_WIDTH-1:0]        rdAddress,
    input  logic [DATA_WIDTH-1:0]        rdData,
    output logic [4*NUM_DIGITS-1:0]      entryDigits,
    output logic [NUM_DIGITS-1:0]        entryBlank,
    output logic [$clog2(ENTRIES+1)-1:0] entryIndex,
    output logic                         entryValid,
    input  logic                         entryReady,
    output logic                         busy,
    output logic                         done
);

    localparam int IW = $clog2(ENTRIES + 1);
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    reader_state_e         state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [IW-1:0]         index_q;
    logic [WW-1:0]         wait_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  conv_load;
    logic                  conv_busy;
    logic                  conv_done;
    logic [IW-1:0]         next_index;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  wait_over;

    // The read word lands on the last WAIT cycle, so the converter loads it right there
    always_comb begin
        wait_over  = (wait_q == WW'(RD_LATENCY - 1));
        conv_load  = (state_q == S_WAIT) && wait_over && !abort;
        next_index = index_q + IW'(1);
        next_addr  = base_q - ADDR_WIDTH'(next_index);
    end

    bin_to_bcd #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin_to_bcd (
        .clk_i    (Clock),
        .reset_i  (reset),
        .load_i   (conv_load),
        .data_i   (rdData),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .digits_o (entryDigits),
        .blank_o  (entryBlank)
    );

    // Run sequencing: fetch, wait out RAM latency, convert, present, repeat newest-first
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            rd_addr_q <= '0;
            index_q   <= '0;
            wait_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort) begin
                state_q <= S_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            base_q    <= latestAddress;
                            rd_addr_q <= latestAddress;
                            index_q   <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        wait_q  <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_over) begin
                            state_q <= S_CONVERT;
                        end else begin
                            wait_q <= wait_q + WW'(1);
                        end
                    end
                    S_CONVERT: begin
                        if (conv_done && !conv_busy) begin
                            valid_q <= 1'b1;
                            state_q <= S_PRESENT;
                        end
                    end
                    S_PRESENT: begin
                        if (entryReady) begin
                            valid_q <= 1'b0;
                            if (index_q == IW'(ENTRIES - 1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                index_q   <= next_index;
                                rd_addr_q <= next_addr;
                                state_q   <= S_FETCH;
                            end
                        end
                    end
                    S_FINISH: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rdAddress  = rd_addr_q;
    assign entryIndex = index_q;
    assign entryValid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_score_history_reader.sv
// tb/tb_score_history_reader.sv - directed self-checking bench for score_history_reader
module tb_score_history_reader;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    logic [31:0] mem [256];

    // main instance: ENTRIES=5
    logic        start, abort, ready;
    logic [7:0]  latest, rd_addr, a_q;
    logic [31:0] d_q;
    logic [39:0] digits;
    logic [9:0]  blank;
    logic [2:0]  idx;
    logic        valid, busy, done;

    // second instance: ENTRIES=1
    logic        start1;
    logic [7:0]  latest1, rd_addr1, a1_q;
    logic [31:0] d1_q;
    logic [39:0] digits1;
    logic [9:0]  blank1;
    logic [0:0]  idx1;
    logic        valid1, busy1, done1;

    always #5 clk = ~clk;

    // two-stage RAM models: registered address, registered data
    always @(posedge clk) begin
        a_q  <= rd_addr;
        d_q  <= mem[a_q];
        a1_q <= rd_addr1;
        d1_q <= mem[a1_q];
    end

    score_history_reader #(.ENTRIES(5)) dut (
        .Clock(clk), .reset(reset), .start(start), .abort(abort),
        .latestAddress(latest), .rdAddress(rd_addr), .rdData(d_q),
        .entryDigits(digits), .entryBlank(blank), .entryIndex(idx),
        .entryValid(valid), .entryReady(ready), .busy(busy), .done(done)
    );

    score_history_reader #(.ENTRIES(1)) dut1 (
        .Clock(clk), .reset(reset), .start(start1), .abort(1'b0),
        .latestAddress(latest1), .rdAddress(rd_addr1), .rdData(d1_q),
        .entryDigits(digits1), .entryBlank(blank1), .entryIndex(idx1),
        .entryValid(valid1), .entryReady(1'b1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    logic [7:0]  exp_addr [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd255};
    logic [39:0] exp_bcd  [5] = '{40'h103, 40'h102, 40'h101, 40'h100, 40'h355};

    initial begin
        bit ok;
        int n, t0, t1, hold, seen;

        for (int i = 0; i < 256; i++) mem[i] = i + 100;
        mem[5] = 32'd0;
        mem[7] = 32'hFFFF_FFFF;
        mem[9] = 32'd1234;

        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0; latest = 8'd0;
        start1 = 1'b0; latest1 = 8'd0;
        repeat (3) tick();
        check("rst_addr", rd_addr, 0);
        check("rst_digits", digits, 0);
        check("rst_blank", blank, 0);
        check("rst_index", idx, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // zero entry, exact first-entry latency and done timing
        latest1 = 8'd5; start1 = 1'b1; tick(); start1 = 1'b0;
        repeat (34) tick();
        check("a_valid_c35", valid1, 0);
        tick();
        check("a_valid_c36", valid1, 1);
        check("a_digits", digits1, 0);
        check("a_blank", blank1, 10'b1111111110);
        tick();
        check("a_done_c37", done1, 1);
        check("a_busy_c37", busy1, 0);
        check("a_valid_c37", valid1, 0);
        tick();
        check("a_done_pulse", done1, 0);

        // maximum word
        latest1 = 8'd7; start1 = 1'b1; tick(); start1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !valid1; i++) tick();
        check("b_valid", valid1, 1);
        check("b_digits", digits1, 40'h4294967295);
        check("b_blank", blank1, 0);
        repeat (3) tick();

        // address wrap, newest first, ignored start/latestAddress during run
        latest = 8'd3; ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        latest = 8'd200;
        check("c_addr0", rd_addr, 3);
        check("c_busy", busy, 1);
        n = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 400 && n < 5; c++) begin
            if (valid) begin
                check("c_index", idx, n);
                check("c_digits", digits, exp_bcd[n]);
                check("c_blank", blank, 10'b1111111000);
                if (n == 0) t0 = cyc;
                if (n == 1) t1 = cyc;
                n++;
                tick();
                if (n < 5) check("c_addr", rd_addr, exp_addr[n]);
                else begin
                    check("c_done", done, 1);
                    check("c_busy_end", busy, 0);
                end
                if (n == 1) begin
                    start = 1'b1; tick(); start = 1'b0;
                end
            end else begin
                tick();
            end
        end
        check("c_count", n, 5);
        check("c_spacing", t1 - t0, 36);
        tick();
        check("c_done_pulse", done, 0);

        // backpressure on entry 1, then abort during entry 2 conversion
        latest = 8'd10; ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        wait_valid(100, ok);
        check("d_v0", ok, 1);
        check("d_idx0", idx, 0);
        tick();
        ready = 1'b0;
        wait_valid(100, ok);
        check("d_v1", ok, 1);
        hold = 0;
        repeat (50) begin
            if (valid && digits == 40'h1234 && idx == 3'd1) hold++;
            tick();
        end
        check("d_hold", hold, 50);
        check("d_digits", digits, 40'h1234);
        check("d_blank", blank, 10'b1111110000);
        ready = 1'b1; tick(); ready = 1'b0;
        check("d_drop", valid, 0);
        check("d_idx2", idx, 2);
        check("d_addr2", rd_addr, 8);
        repeat (20) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("d_abort_busy", busy, 0);
        check("d_abort_valid", valid, 0);
        seen = 0;
        repeat (60) begin
            if (done || valid || busy) seen++;
            tick();
        end
        check("d_quiet", seen, 0);
        ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        wait_valid(100, ok);
        check("d_restart_v", ok, 1);
        check("d_restart_idx", idx, 0);
        check("d_restart_digits", digits, 40'h110);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("d_restart_done", ok, 1);
        tick();

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1; tick();
        check("e_abort_start", busy, 0);
        start = 1'b0; abort = 1'b0; tick();
        check("e_abort_start2", busy, 0);

        // reset during WAIT
        latest = 8'd3; start = 1'b1; tick(); start = 1'b0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("f_addr", rd_addr, 0);
        check("f_digits", digits, 0);
        check("f_blank", blank, 0);
        check("f_index", idx, 0);
        check("f_valid", valid, 0);
        check("f_busy", busy, 0);
        check("f_done", done, 0);
        seen = 0;
        repeat (50) begin
            if (valid || busy) seen++;
            tick();
        end
        check("f_quiet", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_history_reader.md
# score_history_reader

Reads back the per-game scores that the score keeper writes into the 256-entry score memory, newest first, and converts each to packed BCD for the score-view screen renderer. It sits between the score memory's read port and the text/VGA renderer. It is started when the FSM enters the score-view state, and it delivers one entry per valid/ready transfer.

## Interface
- ADDR_WIDTH, 8, score memory address width
- DATA_WIDTH, 32, score word width
- NUM_DIGITS, 10, BCD digits per entry; must cover 2^DATA_WIDTH-1
- ENTRIES, 10, entries listed per run; 1..2^ADDR_WIDTH
- RD_LATENCY, 2, cycles from rdAddress to valid rdData (address and output registered in RAM)
- Clock  in  1  system clock; one clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run (level sampled in IDLE only)
- abort  in  1  cancel run, return to IDLE
- latestAddress  in  ADDR_WIDTH  address of most recent score (score keeper's write address)
- rdAddress  out  ADDR_WIDTH  score memory read address
- rdData  in  DATA_WIDTH  score memory read data
- entryDigits  out  4*NUM_DIGITS  packed BCD, digit 0 (units) in bits [3:0]
- entryBlank  out  NUM_DIGITS  1 = leading zero to blank; bit 0 always 0
- entryIndex  out  $clog2(ENTRIES+1)  0 = newest
- entryValid  out  1  entry outputs valid
- entryReady  in  1  renderer accepts entry
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after final transfer

## Operation
- States: IDLE, FETCH, WAIT, CONVERT, PRESENT, FINISH.
- IDLE: start=1 and abort=0 → capture latestAddress as base, index←0, go to FETCH.
- FETCH (1 cycle): rdAddress = (base - index) mod 2^ADDR_WIDTH; go to WAIT.
- WAIT: count RD_LATENCY-1 cycles, then sample rdData into the shift register and go to CONVERT.
- CONVERT: DATA_WIDTH double-dabble iterations, one per cycle (add 3 to each digit ≥5, then shift left). Then compute entryBlank: bit k set iff digits k..NUM_DIGITS-1 are all zero, with bit 0 forced to 0. Go to PRESENT.
- PRESENT: entryValid=1. On entryValid & entryReady: if index=ENTRIES-1 go to FINISH, else index+1 and go to FETCH.
- FINISH (1 cycle): done=1, then go to IDLE.
- busy=1 in every state except IDLE and FINISH.
- start outside IDLE is ignored. latestAddress changes after capture are ignored.
- Address wrap: base=3, ENTRIES=5 reads 3,2,1,0,255.
- Unwritten or zero entries are presented normally as value 0.
- abort=1 in any non-IDLE state → IDLE next cycle, entryValid=0, no done. abort and start together in IDLE: abort wins, stays IDLE.
- reset overrides everything, mid-run included.

## Timing
- Reset values: rdAddress=0, entryDigits=0, entryBlank=0, entryIndex=0, entryValid=0, busy=0, done=0; state IDLE.
- start sampled at edge 0 → rdAddress valid in cycle 1 → rdData sampled at end of cycle 1+RD_LATENCY → CONVERT occupies the next DATA_WIDTH cycles → entryValid high from cycle RD_LATENCY+DATA_WIDTH+2 (36 at defaults).
- Entry-to-entry with entryReady held high: RD_LATENCY+DATA_WIDTH+2 cycles between transfers.
- entryDigits, entryBlank and entryIndex stay stable while entryValid=1. entryValid drops the cycle after a transfer.
- done is high in the cycle after the final transfer; busy is low in that same cycle.
- entryReady is ignored when entryValid=0.

## Structure
- Shared package score_pkg: ADDR_WIDTH, DATA_WIDTH and NUM_DIGITS defaults, and the reader state encoding. The score keeper uses the same width constants.
- Sub-module bin_to_bcd: sequential double-dabble with a load/start input, a busy/done handshake and a blank-mask output. The top level holds the FSM, address arithmetic and output handshake.

## Test plan
- latestAddress=5, mem[5]=0, ENTRIES=1, ready=1 → entryDigits=0, entryBlank=10'b1111111110, entryValid at cycle 36, done at cycle 37.
- mem[7]=4294967295 → entryDigits BCD 4,2,9,4,9,6,7,2,9,5 (MSD..LSD), entryBlank=0.
- latestAddress=3, ENTRIES=5, mem[i]=i+100 → indices 0..4 carry 103,102,101,100,355 (address 255); rdAddress sequence 3,2,1,0,255.
- entryReady held low 50 cycles on entry 1 (mem=1234) → outputs hold 1234 with valid high; single transfer on release; no duplicate or skipped entry.
- abort asserted during CONVERT of entry 2 → IDLE next cycle, busy=0, no done; a following start begins again at index 0.
- reset pulsed during WAIT, and start pulsed while busy → all outputs return to reset values; start while busy leaves the run sequence unchanged.
